player_position_tracker: RTL and testbench
==========================================

# player_position_tracker

Sequential game-state block that owns the player's position on the 16x16 LED playfield. It converts button levels into single-step moves, with a hold-to-repeat feature. It tracks win and loss conditions and presents the position as 4-bit `row_out`/`col_out`. These outputs feed the one-hot row / integer column decoder directly downstream.

## Interface
- `START_ROW`, default 0: row loaded at reset and at restart (4-bit value).
- `START_COL`, default 7: column loaded at reset and at restart (4-bit value).
- `HOLD_CYCLES`, default 8: cycles a single button must be held before the first auto-repeat move.
- `REPEAT_CYCLES`, default 4: cycles between subsequent auto-repeat moves.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `up`, `down`, `left`, `right`  in  1 each  button levels, active-high, already synchronized to `clk`.
- `hit`  in  1  playfield reports an obstacle at the current (`row_out`, `col_out`).
- `restart`  in  1  synchronous restart request, active-high.
- `row_out`  out  4  current player row (0 = bottom, 15 = goal row).
- `col_out`  out  4  current player column.
- `move_pulse`  out  1  one-cycle pulse in the cycle after any position change.
- `won`  out  1  high while in WON.
- `lost`  out  1  high while in LOST.

## Operation
- **State machine:** three states, PLAY, WON and LOST, with 2-bit encoding. The reset state is PLAY.
- **Button sampling:** button levels are registered into `btn_q[3:0]` every cycle.
  - `single` is high when exactly one of `up`/`down`/`left`/`right` is high.
  - `press` = `single` and the active button was low in `btn_q`.
- **Move request:**
  - A move is requested on `press`.
  - A move is also requested when the repeat counter expires while the same single button remains held.
  - When multiple buttons are high in a cycle, no move is made and the repeat counter clears.
- **Repeat counter:** 8-bit.
  - On `press` it loads `HOLD_CYCLES-1` and counts down each cycle while the same single button is held.
  - At 0 it issues a move and reloads `REPEAT_CYCLES-1`.
  - Releasing the button, or a change to a different button, clears the counter and the held-button record.
- **Move arithmetic:**
  - `up`: row+1, saturating at 15.
  - `down`: row-1, saturating at 0.
  - `left`: col-1 mod 16 (0 wraps to 15).
  - `right`: col+1 mod 16 (15 wraps to 0).
  - A saturated move (no change) does not pulse `move_pulse`.
- **PLAY transitions:**
  - `hit`=1 → LOST. Any move requested that cycle is discarded.
  - Else `row_out`==15 → WON.
  - Else apply any requested move.
- **WON / LOST:** position is frozen and buttons are ignored; the repeat counter is held at 0.
- **`restart`:** valid in any state. Loads `START_ROW`/`START_COL`, goes to PLAY, clears the counter, and takes priority over `hit` and moves. `move_pulse` is not asserted for a restart.

## Timing
- **Reset values:** `row_out`=`START_ROW`, `col_out`=`START_COL`, `move_pulse`=0, `won`=0, `lost`=0, `btn_q`=0, counter=0, state=PLAY.
- **Reset mid-operation:** asserting `reset` takes effect immediately, regardless of state or counter value.
- **Move latency:** a press present at rising edge n updates `row_out`/`col_out` at edge n+1. `move_pulse` is high for exactly the cycle after edge n+1.
- **Hold-to-repeat:**
  - The first auto-repeat move occurs `HOLD_CYCLES` cycles after the press move.
  - Further moves follow every `REPEAT_CYCLES` cycles.
  - With the default parameters, holding `right` from edge n moves at edges n+1, n+9, n+13, n+17, and so on.
- **Loss latency:** `hit` high at edge n → `lost`=1 from edge n+1.
- **Win latency:** `row_out` reaching 15 at edge n → `won`=1 from edge n+1, provided `hit` is low at that edge.
- **All outputs are registered;** there is no combinational path from input to output.

## Test plan
- **Reset and single move:** release `reset` with defaults, then pulse `up` for one cycle. Expected: `row_out` 0→1, `col_out` stays 7, `move_pulse` high for one cycle; a second `up` press gives row 2.
- **Column wrap:** from col 15, press `right` → col 0. From col 0, press `left` → col 15. `move_pulse` asserts both times.
- **Row saturation:** at row 0 press `down` → row stays 0 with no `move_pulse`. Drive to row 15 → `won`=1 one cycle later; further presses do not change the position.
- **Auto-repeat and multi-button:**
  - Hold `right` for 20 cycles from col 0 → col 5 (moves at +1, +9, +13, +17, +21 relative to the press edge; check cycle-exact).
  - Hold `up`+`left` together → no movement.
- **Hit, restart and reset:**
  - Assert `hit` in the same cycle as an `up` press → `lost`=1 and position unchanged.
  - `restart` → row 0, col 7, PLAY, `lost`=0.
  - Assert `reset` low mid-repeat → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/player_position_tracker.sv
// player_position_tracker: player position on the 16x16 playfield with hold-to-repeat moves and win/loss tracking.
module player_position_tracker #(
  parameter logic [3:0] START_ROW     = 4'd0,
  parameter logic [3:0] START_COL     = 4'd7,
  parameter int         HOLD_CYCLES   = 8,
  parameter int         REPEAT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       hit,
  input  logic       restart,
  output logic [3:0] row_out,
  output logic [3:0] col_out,
  output logic       move_pulse,
  output logic       won,
  output logic       lost
);
  typedef enum logic [1:0] {PLAY = 2'd0, WON = 2'd1, LOST = 2'd2} state_t;
  state_t state, state_d;
  logic [3:0] btn, btn_q, held, held_d, row_d, col_d, mv_row, mv_col;
  logic [7:0] cnt, cnt_d;
  logic single, press, same, move_req, pulse_d;
  assign btn      = {up, down, left, right};
  assign single   = $onehot(btn);
  assign press    = single && (btn & btn_q) == 4'd0;
  assign same     = single && btn == held;
  assign move_req = press || (same && cnt == 8'd0);
  assign mv_row   = up ? (row_out == 4'hf ? row_out : row_out + 4'd1) :
                    down ? (row_out == 4'h0 ? row_out : row_out - 4'd1) : row_out;
  assign mv_col   = left ? col_out - 4'd1 : right ? col_out + 4'd1 : col_out;
  assign won      = state == WON;
  assign lost     = state == LOST;
  // Counter and held record default to cleared; only an ongoing single-button hold in PLAY keeps them.
  always_comb begin
    state_d = state;
    row_d   = row_out;
    col_d   = col_out;
    cnt_d   = 8'd0;
    held_d  = 4'd0;
    pulse_d = 1'b0;
    if (restart) begin
      state_d = PLAY;
      row_d   = START_ROW;
      col_d   = START_COL;
    end else if (state == PLAY) begin
      if (hit) state_d = LOST;
      else if (row_out == 4'hf) state_d = WON;
      else begin
        if (press) begin
          held_d = btn;
          cnt_d  = 8'(HOLD_CYCLES - 1);
        end else if (same) begin
          held_d = held;
          cnt_d  = cnt == 8'd0 ? 8'(REPEAT_CYCLES - 1) : cnt - 8'd1;
        end
        if (move_req) begin
          row_d   = mv_row;
          col_d   = mv_col;
          pulse_d = {mv_row, mv_col} != {row_out, col_out};
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PLAY;
      row_out    <= START_ROW;
      col_out    <= START_COL;
      cnt        <= 8'd0;
      held       <= 4'd0;
      btn_q      <= 4'd0;
      move_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      row_out    <= row_d;
      col_out    <= col_d;
      cnt        <= cnt_d;
      held       <= held_d;
      btn_q      <= btn;
      move_pulse <= pulse_d;
    end
  end
endmodule

// File: tb/tb_player_position_tracker.sv
// tb_player_position_tracker: directed checks of moves, wrap/saturation, auto-repeat, win/loss, restart and reset.
module tb_player_position_tracker;
  logic clk = 1'b0, reset = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0, restart = 1'b0;
  logic [3:0] row_out, col_out;
  logic move_pulse, won, lost;
  int n_chk = 0, n_pass = 0;
  localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001, N = 4'b0000;

  player_position_tracker dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .hit(hit), .restart(restart), .row_out(row_out), .col_out(col_out),
    .move_pulse(move_pulse), .won(won), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {up, down, left, right} = b;
  endtask

  task automatic tap(input logic [3:0] b);
    set_btn(N);
    tick();
    set_btn(b);
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_row", 8'(row_out), 8'd0);
    check("rst_col", 8'(col_out), 8'd7);
    check("rst_pulse", 8'(move_pulse), 8'd0);
    check("rst_won", 8'(won), 8'd0);
    check("rst_lost", 8'(lost), 8'd0);
    reset = 1'b1;
    tick();
    // single moves
    tap(U);
    check("up1_row", 8'(row_out), 8'd1);
    check("up1_col", 8'(col_out), 8'd7);
    check("up1_pulse", 8'(move_pulse), 8'd1);
    set_btn(N);
    tick();
    check("up1_pulse_end", 8'(move_pulse), 8'd0);
    tap(U);
    check("up2_row", 8'(row_out), 8'd2);
    tap(D);
    tap(D);
    check("down_row0", 8'(row_out), 8'd0);
    tap(D);
    check("sat_row", 8'(row_out), 8'd0);
    check("sat_pulse", 8'(move_pulse), 8'd0);
    // column wrap
    for (int i = 0; i < 8; i++) tap(R);
    check("col15", 8'(col_out), 8'd15);
    tap(R);
    check("wrap_r_col", 8'(col_out), 8'd0);
    check("wrap_r_pulse", 8'(move_pulse), 8'd1);
    tap(L);
    check("wrap_l_col", 8'(col_out), 8'd15);
    check("wrap_l_pulse", 8'(move_pulse), 8'd1);
    tap(R);
    // auto-repeat: moves at edges 1, 9, 13, 17, 21 after the press
    set_btn(N);
    tick();
    set_btn(R);
    for (int i = 1; i <= 21; i++) begin
      int moves;
      logic mv;
      tick();
      moves = int'(i >= 1) + int'(i >= 9) + int'(i >= 13) + int'(i >= 17) + int'(i >= 21);
      mv = (i == 1) || (i >= 9 && (i - 9) % 4 == 0);
      check($sformatf("rep_col_e%0d", i), 8'(col_out), 8'(moves));
      check($sformatf("rep_pulse_e%0d", i), 8'(move_pulse), 8'(mv));
    end
    // multi-button
    set_btn(N);
    tick();
    set_btn(U | L);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("multi_row", 8'(row_out), 8'd0);
      check("multi_col", 8'(col_out), 8'd5);
      check("multi_pulse", 8'(move_pulse), 8'd0);
    end
    // reset asserted mid-repeat
    set_btn(N);
    tick();
    set_btn(R);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_col", 8'(col_out), 8'd6);
    #2 reset = 1'b0;
    #1;
    check("async_rst_row", 8'(row_out), 8'd0);
    check("async_rst_col", 8'(col_out), 8'd7);
    check("async_rst_pulse", 8'(move_pulse), 8'd0);
    set_btn(N);
    tick();
    reset = 1'b1;
    tick();
    // hit together with a press
    set_btn(U);
    hit = 1'b1;
    tick();
    check("hit_lost", 8'(lost), 8'd1);
    check("hit_row", 8'(row_out), 8'd0);
    check("hit_pulse", 8'(move_pulse), 8'd0);
    hit = 1'b0;
    tap(U);
    check("lost_frozen_row", 8'(row_out), 8'd0);
    check("lost_hold", 8'(lost), 8'd1);
    set_btn(N);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_lost", 8'(lost), 8'd0);
    check("restart_row", 8'(row_out), 8'd0);
    check("restart_col", 8'(col_out), 8'd7);
    check("restart_pulse", 8'(move_pulse), 8'd0);
    // restart outranks hit
    restart = 1'b1;
    hit = 1'b1;
    tick();
    restart = 1'b0;
    hit = 1'b0;
    check("restart_vs_hit", 8'(lost), 8'd0);
    // climb to the goal row
    for (int i = 0; i < 15; i++) tap(U);
    check("goal_row", 8'(row_out), 8'd15);
    check("goal_won_early", 8'(won), 8'd0);
    tick();
    check("won", 8'(won), 8'd1);
    tap(D);
    tap(R);
    check("won_frozen_row", 8'(row_out), 8'd15);
    check("won_frozen_col", 8'(col_out), 8'd7);
    check("won_pulse", 8'(move_pulse), 8'd0);
    set_btn(N);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_won", 8'(won), 8'd0);
    check("restart_row2", 8'(row_out), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
